string_builder: RTL
===================

# string_builder

Parametrised key-driven line editor. It sits behind the board push-buttons in place of the single-character entry path, and holds an editable string of up to DEPTH 8-bit characters. It supports a cursor, candidate-character stepping, commit in insert or overwrite mode, and backspace. Multi-position edits run as a cycle-by-cycle shift state machine, and the stored string is read back through a registered read port for display logic.

## Interface
Parameters:
- DEPTH, 16 — string capacity in characters; must be ≥ 2.
- CHAR_MIN, 8'h20 — first candidate code; reset value of the candidate.
- CHAR_MAX, 8'h7E — last candidate code; the candidate wraps from here to CHAR_MIN.
- INSERT, 1 — 1 = commit inserts at the cursor; 0 = commit overwrites at the cursor.

Widths: AW = $clog2(DEPTH); LW = $clog2(DEPTH+1).

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- i_sclr  in  1  reset; synchronous, active-high.
- i_key_right_n  in  1  cursor right; raw, active-low.
- i_key_down_n  in  1  step the candidate; raw, active-low.
- i_key_left_n  in  1  cursor left; raw, active-low.
- i_key_char_n  in  1  commit the candidate at the cursor; raw, active-low.
- i_key_backspace_n  in  1  delete the character before the cursor; raw, active-low.
- i_raddr  in  AW  read address.
- o_rdata  out  8  registered read data; 0 when i_raddr ≥ o_len.
- o_cand  out  8  current candidate character.
- o_len  out  LW  number of stored characters.
- o_cursor  out  LW  cursor position, 0..o_len.
- o_busy  out  1  shift operation in progress.
- o_full  out  1  o_len == DEPTH.
- o_empty  out  1  o_len == 0.
- o_err  out  1  one-cycle pulse on a rejected command.

## Operation
- Each key passes through a 2-flop synchroniser. Synchroniser flops reset to 1.
- A command is a falling edge (prev 1, now 0) on the synchronised signal. A key held low produces exactly one command.
- Simultaneous commands: priority is backspace > char > right > left > down. Lower-priority commands in that cycle are dropped, and no o_err is raised for them.
- Commands arriving while o_busy = 1 are dropped silently.
- FSM states: IDLE, SHIFT_R, SHIFT_L.
- down: o_cand ← o_cand+1. If o_cand == CHAR_MAX, o_cand ← CHAR_MIN.
- left: if cursor > 0, cursor−1; otherwise o_err.
- right: if cursor < len, cursor+1; otherwise o_err.
- char, with cursor == len (append):
  - If full, o_err.
  - Otherwise mem[len] ← cand, len+1, cursor+1, single cycle.
- char, with cursor < len, INSERT=0: mem[cursor] ← cand, cursor+1, len unchanged.
- char, with cursor < len, INSERT=1:
  - If full, o_err and no change.
  - Otherwise enter SHIFT_R with idx = len.
  - Each SHIFT_R cycle: mem[idx] ← mem[idx−1], then idx−1.
  - In the cycle where idx == cursor+1, also write mem[cursor] ← cand, len+1, cursor+1, and return to IDLE.
- backspace:
  - If cursor == 0, o_err.
  - If cursor == len: len−1, cursor−1, single cycle.
  - Otherwise enter SHIFT_L with idx = cursor−1.
  - Each SHIFT_L cycle: mem[idx] ← mem[idx+1], then idx+1.
  - In the cycle where idx == len−2, also len−1, cursor−1, and return to IDLE.
- o_cand is unaffected by commit and backspace.
- Memory contents are not reset. Slots at or above len are masked on read.

## Timing
- Reset values: o_len=0, o_cursor=0, o_cand=CHAR_MIN, state IDLE, o_busy=0, o_err=0, o_rdata=0, o_empty=1, o_full=0.
- Reset mid-shift: the FSM aborts to IDLE, and all reset values apply on the next edge.
- Command latency: the pin is first sampled low at edge k. The command takes effect at edge k+2, when the single-cycle updates become visible.
- Insert and shift-backspace: o_busy rises at edge k+2 and stays high for exactly len−cursor cycles. Final len and cursor are visible in the same cycle o_busy falls.
- o_err is high for exactly one cycle, at edge k+2.
- Read latency is 1 cycle: o_rdata reflects the i_raddr sampled at the previous edge.
- Reads during o_busy return the partially shifted array. Consumers qualify reads with !o_busy.
- o_full and o_empty are combinational from o_len.

## Test plan
- Reset, then 3× down, then char: o_cand = 8'h23, o_len = 1, o_cursor = 1, mem[0] reads 8'h23 one cycle after i_raddr = 0.
- Append "ABC", 2× left, commit 'X' (INSERT=1): o_busy high for 2 cycles, final string "AXBC", o_cursor = 2, o_len = 4.
- Backspace at cursor 2 of "AXBC": o_busy high for 2 cycles, result "ABC", o_cursor = 1. Backspace at cursor 0 gives an o_err pulse with no change.
- Fill to DEPTH, then commit: o_err pulse, o_full stays 1, contents unchanged. Candidate stepping from 8'h7E wraps to 8'h20.
- Backspace and down pressed in the same cycle: only the backspace executes. A key pressed while o_busy is dropped. A key held low for 10 cycles produces one command.
- i_sclr asserted during SHIFT_R: next cycle o_len = 0, o_busy = 0, reads at any address return 0.

Source files
------------

// File: rtl/string_builder.sv
// string_builder: push-button line editor holding up to DEPTH characters with cursor,
// candidate stepping, insert/overwrite commit and backspace via a shift FSM.
module string_builder #(
  parameter int DEPTH = 16,
  parameter logic [7:0] CHAR_MIN = 8'h20,
  parameter logic [7:0] CHAR_MAX = 8'h7E,
  parameter bit INSERT = 1'b1,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          i_sclr,
  input  logic          i_key_right_n,
  input  logic          i_key_down_n,
  input  logic          i_key_left_n,
  input  logic          i_key_char_n,
  input  logic          i_key_backspace_n,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata,
  output logic [7:0]    o_cand,
  output logic [LW-1:0] o_len,
  output logic [LW-1:0] o_cursor,
  output logic          o_busy,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_err
);
  typedef enum logic [1:0] {IDLE, SHIFT_R, SHIFT_L} state_t;
  localparam logic [LW-1:0] ONE = LW'(1);
  localparam logic [LW-1:0] TWO = LW'(2);
  localparam logic [LW-1:0] CAP = LW'(DEPTH);
  state_t state;
  logic [4:0] keys, s1, s2, s3, cmd;
  logic [LW-1:0] idx, idx_dn, idx_up;
  logic [7:0] mem [DEPTH];
  logic c_bs, c_ch, c_rt, c_lt, c_dn, at_end, r_done, l_done, cand_wr;
  assign keys = {i_key_backspace_n, i_key_char_n, i_key_right_n, i_key_left_n, i_key_down_n};
  // falling edge of the synchronised key, then fixed priority bs > char > right > left > down
  assign cmd = s3 & ~s2;
  assign c_bs = cmd[4];
  assign c_ch = cmd[3] & ~cmd[4];
  assign c_rt = cmd[2] & ~|cmd[4:3];
  assign c_lt = cmd[1] & ~|cmd[4:2];
  assign c_dn = cmd[0] & ~|cmd[4:1];
  assign at_end = o_cursor == o_len;
  assign idx_dn = idx - ONE;
  assign idx_up = idx + ONE;
  assign r_done = idx == o_cursor + ONE;
  assign l_done = idx == o_len - TWO;
  assign o_full = o_len == CAP;
  assign o_empty = o_len == '0;
  assign o_busy = state != IDLE;
  assign cand_wr = (state == IDLE && c_ch && (at_end ? !o_full : !INSERT)) || (state == SHIFT_R && r_done);
  always_ff @(posedge clk) begin
    if (cand_wr) mem[o_cursor[AW-1:0]] <= o_cand;
    if (state == SHIFT_R) mem[idx[AW-1:0]] <= mem[idx_dn[AW-1:0]];
    if (state == SHIFT_L) mem[idx[AW-1:0]] <= mem[idx_up[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
      state <= IDLE;
      idx <= '0;
      o_len <= '0;
      o_cursor <= '0;
      o_cand <= CHAR_MIN;
      o_err <= 1'b0;
      o_rdata <= 8'h00;
    end else begin
      s1 <= keys;
      s2 <= s1;
      s3 <= s2;
      o_err <= 1'b0;
      o_rdata <= (LW'(i_raddr) < o_len) ? mem[i_raddr] : 8'h00;
      case (state)
        IDLE: begin
          if (c_bs) begin
            if (o_cursor == '0) o_err <= 1'b1;
            else if (at_end) begin
              o_len <= o_len - ONE;
              o_cursor <= o_cursor - ONE;
            end else begin
              state <= SHIFT_L;
              idx <= o_cursor - ONE;
            end
          end else if (c_ch) begin
            if (at_end) begin
              if (o_full) o_err <= 1'b1;
              else begin
                o_len <= o_len + ONE;
                o_cursor <= o_cursor + ONE;
              end
            end else if (!INSERT) o_cursor <= o_cursor + ONE;
            else if (o_full) o_err <= 1'b1;
            else begin
              state <= SHIFT_R;
              idx <= o_len;
            end
          end else if (c_rt) begin
            if (at_end) o_err <= 1'b1;
            else o_cursor <= o_cursor + ONE;
          end else if (c_lt) begin
            if (o_cursor == '0) o_err <= 1'b1;
            else o_cursor <= o_cursor - ONE;
          end else if (c_dn) o_cand <= (o_cand == CHAR_MAX) ? CHAR_MIN : o_cand + 8'd1;
        end
        SHIFT_R: begin
          idx <= idx_dn;
          if (r_done) begin
            o_len <= o_len + ONE;
            o_cursor <= o_cursor + ONE;
            state <= IDLE;
          end
        end
        SHIFT_L: begin
          idx <= idx_up;
          if (l_done) begin
            o_len <= o_len - ONE;
            o_cursor <= o_cursor - ONE;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
